// File: rtl/alu_arbiter.sv
// alu_arbiter
//   Shares one combinational 16-bit ALU between NUM_REQ requesters.
//   A round-robin arbiter picks one pending operation per IDLE cycle and
//   registers its operands onto the ALU inputs. One cycle later it captures
//   the ALU result and flags, then presents them to the winning requester
//   until that requester accepts them.
//
// Ports
//   clk, rst_n     rising-edge clock, asynchronous active-low reset
//   req_valid      per-requester operation valid
//   req_ready      per-requester accept (one-hot or zero, IDLE only)
//   req_a, req_b   16-bit operands, requester i at [16i+15:16i]
//   req_op         4-bit op_code, requester i at [4i+3:4i]
//   alu_a/b/op     registered operands driving the external ALU
//   alu_result     ALU result
//   alu_zero/carry/overflow  ALU flags
//   rsp_valid      per-requester response valid (one-hot or zero, RESP only)
//   rsp_ready      per-requester response accept
//   rsp_result     registered ALU result
//   rsp_flags      registered {zero, carry, overflow}
//   grant_id       index of the current or most recent winner
//   busy           high whenever the FSM is not in IDLE
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high for the same requester. req_ready never depends on any requester
// other than through the arbitration of req_valid, and once a requester
// raises req_valid it holds valid and operands until accepted (dropping
// valid beforehand simply removes it from arbitration). rsp_valid, once
// raised, stays high with stable data until rsp_ready of that requester.

module alu_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [16*NUM_REQ-1:0]  req_a,
  input  logic [16*NUM_REQ-1:0]  req_b,
  input  logic [4*NUM_REQ-1:0]   req_op,
  output logic [15:0]            alu_a,
  output logic [15:0]            alu_b,
  output logic [3:0]             alu_op,
  input  logic [15:0]            alu_result,
  input  logic                   alu_zero,
  input  logic                   alu_carry,
  input  logic                   alu_overflow,
  output logic [NUM_REQ-1:0]     rsp_valid,
  input  logic [NUM_REQ-1:0]     rsp_ready,
  output logic [15:0]            rsp_result,
  output logic [2:0]             rsp_flags,
  output logic [ID_W-1:0]        grant_id,
  output logic                   busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  // Pointer reset value makes requester 0 the first in search order.
  localparam logic [ID_W-1:0] LAST_RST = ID_W'(NUM_REQ - 1);

  state_e          state_q, state_d;
  logic [15:0]     alu_a_q, alu_a_d;
  logic [15:0]     alu_b_q, alu_b_d;
  logic [3:0]      alu_op_q, alu_op_d;
  logic [15:0]     rsp_result_q, rsp_result_d;
  logic [2:0]      rsp_flags_q, rsp_flags_d;
  logic [ID_W-1:0] grant_id_q, grant_id_d;
  logic [ID_W-1:0] last_grant_q, last_grant_d;

  // Unpacked views of the packed operand buses.
  logic [15:0] a_arr  [NUM_REQ];
  logic [15:0] b_arr  [NUM_REQ];
  logic [3:0]  op_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign a_arr[g]  = req_a[16*g +: 16];
    assign b_arr[g]  = req_b[16*g +: 16];
    assign op_arr[g] = req_op[4*g +: 4];
  end

  // Round-robin search: last_grant+1, +2, ... wrapping at NUM_REQ.
  // The pointer itself is the lowest-priority candidate.
  logic            win_found;
  logic [ID_W-1:0] win_id;

  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      int              idx;
      logic [ID_W-1:0] cand;
      idx = int'(last_grant_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      cand = ID_W'(idx);
      if (!win_found && req_valid[cand]) begin
        win_found = 1'b1;
        win_id    = cand;
      end
    end
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_d      = state_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_op_d     = alu_op_q;
    rsp_result_d = rsp_result_q;
    rsp_flags_d  = rsp_flags_q;
    grant_id_d   = grant_id_q;
    last_grant_d = last_grant_q;
    req_ready    = '0;
    rsp_valid    = '0;

    case (state_q)
      IDLE: begin
        if (win_found) begin
          req_ready[win_id] = 1'b1;
          alu_a_d           = a_arr[win_id];
          alu_b_d           = b_arr[win_id];
          alu_op_d          = op_arr[win_id];
          grant_id_d        = win_id;
          state_d           = EXEC;
        end
      end
      EXEC: begin
        rsp_result_d = alu_result;
        rsp_flags_d  = {alu_zero, alu_carry, alu_overflow};
        state_d      = RESP;
      end
      RESP: begin
        rsp_valid[grant_id_q] = 1'b1;
        // Only the granted requester's ready can complete the response;
        // the pointer advances here, never on acceptance.
        if (rsp_ready[grant_id_q]) begin
          last_grant_d = grant_id_q;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_op_q     <= '0;
      rsp_result_q <= '0;
      rsp_flags_q  <= '0;
      grant_id_q   <= '0;
      last_grant_q <= LAST_RST;
    end else begin
      state_q      <= state_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_op_q     <= alu_op_d;
      rsp_result_q <= rsp_result_d;
      rsp_flags_q  <= rsp_flags_d;
      grant_id_q   <= grant_id_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_op     = alu_op_q;
  assign rsp_result = rsp_result_q;
  assign rsp_flags  = rsp_flags_q;
  assign grant_id   = grant_id_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;
  localparam int W       = ID_W + 16 + 3;

  logic                  clk;
  logic                  rst_n;
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [16*NUM_REQ-1:0] req_a;
  logic [16*NUM_REQ-1:0] req_b;
  logic [4*NUM_REQ-1:0]  req_op;
  logic [15:0]           alu_a;
  logic [15:0]           alu_b;
  logic [3:0]            alu_op;
  logic [15:0]           alu_result;
  logic                  alu_zero;
  logic                  alu_carry;
  logic                  alu_overflow;
  logic [NUM_REQ-1:0]    rsp_valid;
  logic [NUM_REQ-1:0]    rsp_ready;
  logic [15:0]           rsp_result;
  logic [2:0]            rsp_flags;
  logic [ID_W-1:0]       grant_id;
  logic                  busy;

  alu_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_a        (req_a),
    .req_b        (req_b),
    .req_op       (req_op),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_op       (alu_op),
    .alu_result   (alu_result),
    .alu_zero     (alu_zero),
    .alu_carry    (alu_carry),
    .alu_overflow (alu_overflow),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_result   (rsp_result),
    .rsp_flags    (rsp_flags),
    .grant_id     (grant_id),
    .busy         (busy)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- ALU stand-in ----------------
  // 0 ADD, 1 SUB (carry = borrow), 2 AND, 3 OR, 4 XOR, others give 0.
  always_comb begin
    logic [16:0] wide;
    wide         = '0;
    alu_carry    = 1'b0;
    alu_overflow = 1'b0;
    case (alu_op)
      4'h0: begin
        wide         = {1'b0, alu_a} + {1'b0, alu_b};
        alu_carry    = wide[16];
        alu_overflow = (alu_a[15] == alu_b[15]) && (wide[15] != alu_a[15]);
      end
      4'h1: begin
        wide         = {1'b0, alu_a} - {1'b0, alu_b};
        alu_carry    = wide[16];
        alu_overflow = (alu_a[15] != alu_b[15]) && (wide[15] != alu_a[15]);
      end
      4'h2: wide = {1'b0, alu_a & alu_b};
      4'h3: wide = {1'b0, alu_a | alu_b};
      4'h4: wide = {1'b0, alu_a ^ alu_b};
      default: wide = '0;
    endcase
    alu_result = wide[15:0];
    alu_zero   = (wide[15:0] == 16'h0000);
  end

  // ---------------- scoreboard ----------------
  logic [W-1:0]    exp_q[$];   // {id, result, flags}
  logic [ID_W-1:0] acc_q[$];   // expected grant order
  int              acc_cyc_q[$];
  int              n_checks = 0;
  int              n_errors = 0;
  int              n_acc    = 0;
  logic [NUM_REQ-1:0] acc_mask = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [ID_W-1:0] idx_of(input logic [NUM_REQ-1:0] v);
    logic [ID_W-1:0] r;
    r = '0;
    for (int i = 0; i < NUM_REQ; i++) if (v[i]) r = ID_W'(i);
    return r;
  endfunction

  task automatic expect_rsp(input int id, input logic [15:0] res, input logic [2:0] flg);
    logic [ID_W-1:0] idv;
    idv = ID_W'(id);
    exp_q.push_back({idv, res, flg});
  endtask

  task automatic expect_acc(input int id);
    acc_q.push_back(ID_W'(id));
  endtask

  // Monitor: acceptance order and response contents.
  always @(negedge clk) begin
    if (!rst_n) begin
      acc_mask = '0;
    end else begin
      acc_mask = req_valid & req_ready;
      if (req_ready != '0) begin
        check("req_ready_onehot", 32'($countones(req_ready)), 32'd1);
        n_acc++;
        acc_cyc_q.push_back(cyc);
        if (acc_q.size() == 0) begin
          check("unexpected_accept", 32'(req_ready), 32'd0);
        end else begin
          logic [ID_W-1:0] e;
          e = acc_q.pop_front();
          check("grant_order", 32'(idx_of(req_ready)), 32'(e));
        end
      end
      if (rsp_valid != '0) begin
        check("rsp_valid_onehot", 32'($countones(rsp_valid)), 32'd1);
        if ((rsp_valid & rsp_ready) != '0) begin
          if (exp_q.size() == 0) begin
            check("unexpected_rsp", 32'(rsp_valid), 32'd0);
          end else begin
            logic [W-1:0] e;
            e = exp_q.pop_front();
            check("rsp_id",     32'(idx_of(rsp_valid)), 32'(e[W-1 -: ID_W]));
            check("rsp_grant",  32'(grant_id),          32'(e[W-1 -: ID_W]));
            check("rsp_result", 32'(rsp_result),        32'(e[18:3]));
            check("rsp_flags",  32'(rsp_flags),         32'(e[2:0]));
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Advance one cycle and drop valid of requesters accepted on that edge.
  task automatic tick_drop();
    @(posedge clk);
    #1;
    req_valid = req_valid & ~acc_mask;
  endtask

  task automatic set_req(input int id, input logic [15:0] a, input logic [15:0] b,
                         input logic [3:0] op);
    req_a[16*id +: 16] = a;
    req_b[16*id +: 16] = b;
    req_op[4*id +: 4]  = op;
    req_valid[id]      = 1'b1;
  endtask

  task automatic reset_dut();
    rst_n     = 1'b0;
    req_valid = '0;
    rsp_ready = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic wait_idle(input string name, input int max);
    int n;
    n = 0;
    while ((busy || req_valid != '0) && n < max) begin
      tick_drop();
      n++;
    end
    check(name, 32'(busy || req_valid != '0), 32'd0);
  endtask

  // ---------------- directed tests ----------------
  initial begin
    int base, n, target;
    rst_n     = 1'b0;
    req_valid = '0;
    rsp_ready = '0;
    req_a     = '0;
    req_b     = '0;
    req_op    = '0;
    #12;
    // Reset state
    check("rst_busy",       32'(busy),       32'd0);
    check("rst_rsp_valid",  32'(rsp_valid),  32'd0);
    check("rst_req_ready",  32'(req_ready),  32'd0);
    check("rst_alu_a",      32'(alu_a),      32'd0);
    check("rst_alu_op",     32'(alu_op),     32'd0);
    check("rst_rsp_result", 32'(rsp_result), 32'd0);
    check("rst_rsp_flags",  32'(rsp_flags),  32'd0);
    check("rst_grant_id",   32'(grant_id),   32'd0);
    reset_dut();

    // ADD single requester: 7FFF + 1 = 8000, signed overflow
    rsp_ready = '0;
    set_req(0, 16'h7FFF, 16'h0001, 4'h0);
    expect_acc(0);
    expect_rsp(0, 16'h8000, 3'b001);
    #1;
    check("add_req_ready", 32'(req_ready), 32'h1);
    tick_drop();
    check("add_exec_busy",  32'(busy),      32'd1);
    check("add_exec_alu_a", 32'(alu_a),     32'h7FFF);
    check("add_exec_alu_b", 32'(alu_b),     32'h0001);
    check("add_exec_rsp",   32'(rsp_valid), 32'd0);
    check("add_exec_ready", 32'(req_ready), 32'd0);
    tick();
    check("add_rsp_valid",  32'(rsp_valid),  32'h1);
    check("add_rsp_result", 32'(rsp_result), 32'h8000);
    check("add_rsp_flags",  32'(rsp_flags),  32'h1);
    rsp_ready = 4'b0001;
    tick();
    check("add_done_valid", 32'(rsp_valid), 32'd0);
    check("add_done_busy",  32'(busy),      32'd0);
    rsp_ready = '0;

    // Round-robin, all requesters held valid with SUB 5-3
    reset_dut();
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 16'd5, 16'd3, 4'h1);
    rsp_ready = 4'b1111;
    for (int k = 0; k < 6; k++) begin
      expect_acc(k % NUM_REQ);
      expect_rsp(k % NUM_REQ, 16'h0002, 3'b000);
    end
    base   = acc_cyc_q.size();
    target = n_acc + 6;
    n      = 0;
    while (n_acc < target && n < 40) begin
      tick();
      n++;
    end
    check("rr_timeout", 32'(n_acc), 32'(target));
    req_valid = '0;
    wait_idle("rr_drain", 10);
    for (int i = 1; i < 6; i++)
      if (base + i < acc_cyc_q.size())
        check("rr_spacing", 32'(acc_cyc_q[base+i] - acc_cyc_q[base+i-1]), 32'd3);
    check("rr_queue_empty", 32'(exp_q.size()), 32'd0);

    // Pointer rotation: last completion was requester 1
    set_req(0, 16'hF0F0, 16'hFF00, 4'h2);
    set_req(1, 16'h0F00, 16'h00F0, 4'h3);
    expect_acc(0);
    expect_rsp(0, 16'hF000, 3'b000);
    expect_acc(1);
    expect_rsp(1, 16'h0FF0, 3'b000);
    #1;
    check("rot_first_grant", 32'(req_ready), 32'h1);
    wait_idle("rot_drain", 20);

    // Response backpressure on requester 2 with requester 3 waiting
    rsp_ready = '0;
    set_req(2, 16'hA5A5, 16'hA5A5, 4'h4);
    expect_acc(2);
    expect_rsp(2, 16'h0000, 3'b100);
    tick_drop();
    set_req(3, 16'h0001, 16'h0001, 4'h0);
    expect_acc(3);
    expect_rsp(3, 16'h0002, 3'b000);
    tick();
    for (int i = 0; i < 5; i++) begin
      check("bp_rsp_valid",  32'(rsp_valid),  32'h4);
      check("bp_rsp_result", 32'(rsp_result), 32'h0);
      check("bp_rsp_flags",  32'(rsp_flags),  32'h4);
      check("bp_req_ready",  32'(req_ready),  32'h0);
      tick();
    end
    rsp_ready = 4'b0100;
    #1;
    check("bp_release_valid", 32'(rsp_valid), 32'h4);
    tick();
    check("bp_done_busy", 32'(busy),      32'd0);
    check("bp_grant3",    32'(req_ready), 32'h8);
    rsp_ready = 4'b1111;
    wait_idle("bp_drain", 20);

    // Async reset mid-EXEC discards the transaction
    set_req(0, 16'h1234, 16'h0001, 4'h0);
    expect_acc(0);
    tick_drop();
    check("ar_exec_busy",  32'(busy),  32'd1);
    check("ar_exec_alu_a", 32'(alu_a), 32'h1234);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_rsp_valid", 32'(rsp_valid), 32'd0);
    check("ar_busy",      32'(busy),      32'd0);
    check("ar_alu_a",     32'(alu_a),     32'd0);
    check("ar_grant_id",  32'(grant_id),  32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    set_req(0, 16'h0010, 16'h0020, 4'h1);
    set_req(3, 16'hFFFF, 16'h0001, 4'h0);
    expect_acc(0);
    expect_rsp(0, 16'hFFF0, 3'b010);
    expect_acc(3);
    expect_rsp(3, 16'h0000, 3'b110);
    #1;
    check("ar_first_grant", 32'(req_ready), 32'h1);
    wait_idle("ar_drain", 20);

    // Wrong-requester ready while responding to requester 3; undefined op
    rsp_ready = 4'b0111;
    set_req(3, 16'h0001, 16'h0002, 4'hC);
    expect_acc(3);
    expect_rsp(3, 16'h0000, 3'b100);
    tick_drop();
    check("wr_alu_op", 32'(alu_op), 32'hC);
    tick();
    for (int i = 0; i < 4; i++) begin
      check("wr_rsp_valid", 32'(rsp_valid), 32'h8);
      check("wr_busy",      32'(busy),      32'd1);
      tick();
    end
    rsp_ready = 4'b1000;
    tick();
    check("wr_done_busy",  32'(busy),      32'd0);
    check("wr_done_valid", 32'(rsp_valid), 32'd0);
    rsp_ready = '0;

    tick();
    check("final_rsp_queue", 32'(exp_q.size()), 32'd0);
    check("final_acc_queue", 32'(acc_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
